// File: rtl/cmd_stream_loader.sv
// Packs a valid/ready stream of WORD_WIDTH words into CMD_WIDTH commands and
// issues one command-memory write per packed command at consecutive addresses.
module cmd_stream_loader #(
   parameter int CMD_WIDTH      = 128,
   parameter int WORD_WIDTH     = 32,
   parameter int CMD_ADDR_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [CMD_ADDR_WIDTH-1:0] start_addr,
   input  logic [CMD_ADDR_WIDTH:0]   num_cmds,
   input  logic [WORD_WIDTH-1:0]     word_in,
   input  logic                      word_valid,
   output logic                      word_ready,
   output logic [CMD_ADDR_WIDTH-1:0] cmd_write_addr,
   output logic [CMD_WIDTH-1:0]      cmd_write,
   output logic                      cmd_write_enable,
   output logic                      busy,
   output logic                      done
);
   localparam int WPC   = CMD_WIDTH / WORD_WIDTH;
   localparam int CNT_W = (WPC > 1) ? $clog2(WPC) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(WPC - 1);
   localparam logic [CNT_W-1:0]          CNT_ONE  = CNT_W'(1);
   localparam logic [CMD_ADDR_WIDTH-1:0] ADDR_ONE = CMD_ADDR_WIDTH'(1);
   localparam logic [CMD_ADDR_WIDTH:0]   REM_ONE  = (CMD_ADDR_WIDTH + 1)'(1);

   logic [1:0]                state_q, state_d;
   logic [CNT_W-1:0]          word_cnt_q, word_cnt_d;
   logic [CMD_WIDTH-1:0]      cmd_buf_q, cmd_buf_d;
   logic [CMD_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
   logic [CMD_ADDR_WIDTH:0]   remaining_q, remaining_d;
   logic                      word_ready_q, word_ready_d;
   logic [CMD_ADDR_WIDTH-1:0] cmd_write_addr_q, cmd_write_addr_d;
   logic [CMD_WIDTH-1:0]      cmd_write_q, cmd_write_d;
   logic                      cmd_write_enable_q, cmd_write_enable_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;

   logic [CMD_WIDTH-1:0]      merged_buf;
   logic                      accept;

   assign accept = (state_q == ST_LOAD) && word_valid && word_ready_q;

   // Buffer with the incoming word dropped into its slot; first word lands in the LSBs.
   for (genvar gi = 0; gi < WPC; gi++) begin : g_slot
      assign merged_buf[WORD_WIDTH*gi +: WORD_WIDTH] =
         (word_cnt_q == CNT_W'(gi)) ? word_in : cmd_buf_q[WORD_WIDTH*gi +: WORD_WIDTH];
   end

   always_comb begin
      state_d            = state_q;
      word_cnt_d         = word_cnt_q;
      cmd_buf_d          = cmd_buf_q;
      cur_addr_d         = cur_addr_q;
      remaining_d        = remaining_q;
      cmd_write_addr_d   = cmd_write_addr_q;
      cmd_write_d        = cmd_write_q;
      cmd_write_enable_d = 1'b0;
      done_d             = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cur_addr_d  = start_addr;
               remaining_d = num_cmds;
               word_cnt_d  = '0;
               state_d     = (num_cmds == '0) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               cmd_buf_d = merged_buf;
               if (word_cnt_q == CNT_LAST) begin
                  word_cnt_d         = '0;
                  cmd_write_d        = merged_buf;
                  cmd_write_addr_d   = cur_addr_q;
                  cmd_write_enable_d = 1'b1;
                  state_d            = ST_WRITE;
               end else begin
                  word_cnt_d = word_cnt_q + CNT_ONE;
               end
            end
         end
         ST_WRITE: begin
            cur_addr_d  = cur_addr_q + ADDR_ONE;
            remaining_d = remaining_q - REM_ONE;
            word_cnt_d  = '0;
            state_d     = (remaining_q == REM_ONE) ? ST_DONE : ST_LOAD;
         end
         default: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
      endcase

      // Abort overrides everything decided above, including a write on the last word.
      if (abort) begin
         state_d            = ST_IDLE;
         word_cnt_d         = '0;
         cmd_buf_d          = '0;
         cmd_write_d        = cmd_write_q;
         cmd_write_addr_d   = cmd_write_addr_q;
         cmd_write_enable_d = 1'b0;
         done_d             = 1'b0;
      end

      word_ready_d = (state_d == ST_LOAD);
      busy_d       = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q            <= ST_IDLE;
         word_cnt_q         <= '0;
         cmd_buf_q          <= '0;
         cur_addr_q         <= '0;
         remaining_q        <= '0;
         word_ready_q       <= 1'b0;
         cmd_write_addr_q   <= '0;
         cmd_write_q        <= '0;
         cmd_write_enable_q <= 1'b0;
         busy_q             <= 1'b0;
         done_q             <= 1'b0;
      end else begin
         state_q            <= state_d;
         word_cnt_q         <= word_cnt_d;
         cmd_buf_q          <= cmd_buf_d;
         cur_addr_q         <= cur_addr_d;
         remaining_q        <= remaining_d;
         word_ready_q       <= word_ready_d;
         cmd_write_addr_q   <= cmd_write_addr_d;
         cmd_write_q        <= cmd_write_d;
         cmd_write_enable_q <= cmd_write_enable_d;
         busy_q             <= busy_d;
         done_q             <= done_d;
      end
   end

   assign word_ready       = word_ready_q;
   assign cmd_write_addr   = cmd_write_addr_q;
   assign cmd_write        = cmd_write_q;
   assign cmd_write_enable = cmd_write_enable_q;
   assign busy             = busy_q;
   assign done             = done_q;
endmodule
